// File: rtl/lsu_load_sequencer.sv
// lsu_load_sequencer: multi-cycle sequencer for the zero-extending fixed-point
// loads. It reads the base register, forms the EA, performs one handshaked
// data-cache access and writes the zero-extended result back to RT.
// Bit numbering in comments follows the big-endian convention (bit 0 = MSB).
module lsu_load_sequencer #(
    parameter int unsigned DC_TIMEOUT = 255
) (
    input  logic        i_clk,
    input  logic        i_rst,
    input  logic        i_start,
    input  logic [4:0]  i_rt,
    input  logic [4:0]  i_ra,
    input  logic [63:0] i_disp,
    input  logic        i_use_cia,
    input  logic [63:0] i_cia,
    input  logic        i_32b_mode,
    input  logic [1:0]  i_size,
    output logic [4:0]  o_rf_addr,
    output logic        o_rf_enr,
    input  logic [63:0] i_rf_rdata,
    output logic        o_rf_enw,
    output logic [63:0] o_rf_wdata,
    output logic        o_dc_req_valid,
    input  logic        i_dc_req_ready,
    output logic [63:0] o_dc_addr,
    output logic [1:0]  o_dc_size,
    input  logic        i_dc_rsp_valid,
    input  logic [63:0] i_dc_rsp_data,
    input  logic        i_flush,
    output logic        o_stall,
    output logic        o_done,
    output logic        o_err_invalid,
    output logic        o_err_timeout
);

    localparam int unsigned CNT_W = $clog2(DC_TIMEOUT + 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_RDRA,
        S_ADDR,
        S_REQ,
        S_WAIT,
        S_WB,
        S_DRAIN
    } state_t;

    state_t       r_state;
    state_t       w_next;

    logic [4:0]   r_rt;
    logic         r_use_ra;
    logic [63:0]  r_disp;
    logic [63:0]  r_base;
    logic         r_32b;
    logic [1:0]   r_size;
    logic [63:0]  r_ea;
    logic [CNT_W-1:0] r_cnt;
    logic [63:0]  r_data;

    logic [4:0]   r_rf_addr;
    logic         r_rf_enr;
    logic         r_rf_enw;
    logic         r_dc_req_valid;
    logic         r_stall;
    logic         r_done;
    logic         r_err_invalid;
    logic         r_err_timeout;

    logic [63:0]  w_base;
    logic [63:0]  w_ea_sum;
    logic [63:0]  w_ea;
    logic [63:0]  w_rsp_ext;
    logic         w_cnt_hit;
    logic         w_err_invalid;
    logic         w_err_timeout;
    logic [4:0]   w_rf_addr;

    // EA formation: carry out of bit 0 drops; 32-bit mode clears bits 0:31.
    assign w_base   = r_use_ra ? i_rf_rdata : r_base;
    assign w_ea_sum = w_base + r_disp;
    assign w_ea     = r_32b ? {32'd0, w_ea_sum[31:0]} : w_ea_sum;
    assign w_cnt_hit = (r_cnt == CNT_W'(DC_TIMEOUT - 1));

    // Zero-extend the right-justified response to the access size.
    always_comb begin
        w_rsp_ext = 64'd0;
        case (r_size)
            2'b00:   w_rsp_ext = {56'd0, i_dc_rsp_data[7:0]};
            2'b01:   w_rsp_ext = {48'd0, i_dc_rsp_data[15:0]};
            2'b10:   w_rsp_ext = {32'd0, i_dc_rsp_data[31:0]};
            default: w_rsp_ext = i_dc_rsp_data;
        endcase
    end

    // Next-state and error-pulse decode.
    always_comb begin
        w_next        = r_state;
        w_err_invalid = 1'b0;
        w_err_timeout = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (i_start) begin
                    if (i_use_cia && (i_ra != 5'd0)) w_err_invalid = 1'b1;
                    else if (i_ra != 5'd0)           w_next = S_RDRA;
                    else                             w_next = S_ADDR;
                end
            end
            S_RDRA: w_next = i_flush ? S_IDLE : S_ADDR;
            S_ADDR: w_next = i_flush ? S_IDLE : S_REQ;
            S_REQ: begin
                if (i_flush) begin
                    w_next = i_dc_req_ready ? S_DRAIN : S_IDLE;
                end else if (i_dc_req_ready) begin
                    w_next = S_WAIT;
                end else if (w_cnt_hit) begin
                    w_next        = S_IDLE;
                    w_err_timeout = 1'b1;
                end
            end
            S_WAIT: begin
                if (i_flush) begin
                    w_next = i_dc_rsp_valid ? S_IDLE : S_DRAIN;
                end else if (i_dc_rsp_valid) begin
                    w_next = S_WB;
                end else if (w_cnt_hit) begin
                    w_next        = S_DRAIN;
                    w_err_timeout = 1'b1;
                end
            end
            S_WB:    w_next = S_IDLE;
            S_DRAIN: if (i_dc_rsp_valid) w_next = S_IDLE;
            default: w_next = S_IDLE;
        endcase
    end

    // Register-file index follows the state being entered.
    always_comb begin
        w_rf_addr = 5'd0;
        if (w_next == S_RDRA)    w_rf_addr = i_ra;
        else if (w_next == S_WB) w_rf_addr = r_rt;
    end

    // State register.
    always_ff @(posedge i_clk) begin
        if (i_rst) r_state <= S_IDLE;
        else       r_state <= w_next;
    end

    // Operand latch, EA, timeout counter and response capture.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_rt     <= 5'd0;
            r_use_ra <= 1'b0;
            r_disp   <= 64'd0;
            r_base   <= 64'd0;
            r_32b    <= 1'b0;
            r_size   <= 2'b00;
            r_ea     <= 64'd0;
            r_cnt    <= '0;
            r_data   <= 64'd0;
        end else begin
            if (r_state == S_IDLE && i_start) begin
                r_rt     <= i_rt;
                r_use_ra <= (i_ra != 5'd0);
                r_disp   <= i_disp;
                r_base   <= i_use_cia ? i_cia : 64'd0;
                r_32b    <= i_32b_mode;
                r_size   <= i_size;
            end
            if (r_state == S_ADDR) begin
                r_ea  <= w_ea;
                r_cnt <= '0;
            end else if (r_state == S_REQ || r_state == S_WAIT) begin
                r_cnt <= r_cnt + CNT_W'(1);
            end
            if (r_state == S_WAIT && i_dc_rsp_valid) r_data <= w_rsp_ext;
        end
    end

    // Registered control outputs, decoded from the state being entered.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_rf_addr      <= 5'd0;
            r_rf_enr       <= 1'b0;
            r_rf_enw       <= 1'b0;
            r_dc_req_valid <= 1'b0;
            r_stall        <= 1'b0;
            r_done         <= 1'b0;
            r_err_invalid  <= 1'b0;
            r_err_timeout  <= 1'b0;
        end else begin
            r_rf_addr      <= w_rf_addr;
            r_rf_enr       <= (w_next == S_RDRA);
            r_rf_enw       <= (w_next == S_WB);
            r_dc_req_valid <= (w_next == S_REQ);
            r_stall        <= (w_next inside {S_RDRA, S_ADDR, S_REQ, S_WAIT, S_DRAIN});
            r_done         <= (w_next == S_WB);
            r_err_invalid  <= w_err_invalid;
            r_err_timeout  <= w_err_timeout;
        end
    end

    assign o_rf_addr      = r_rf_addr;
    assign o_rf_enr       = r_rf_enr;
    assign o_rf_enw       = r_rf_enw;
    assign o_rf_wdata     = r_data;
    assign o_dc_req_valid = r_dc_req_valid;
    assign o_dc_addr      = r_ea;
    assign o_dc_size      = r_size;
    assign o_stall        = r_stall;
    assign o_done         = r_done;
    assign o_err_invalid  = r_err_invalid;
    assign o_err_timeout  = r_err_timeout;

endmodule

// File: tb/tb_lsu_load_sequencer.sv
// Self-checking bench for lsu_load_sequencer: directed scenarios plus random
// loads compared against an arithmetic reference model.
module tb_lsu_load_sequencer;

    localparam int unsigned TMO = 16;

    logic        i_clk = 1'b0;
    logic        i_rst = 1'b1;
    logic        i_start = 1'b0;
    logic [4:0]  i_rt = '0;
    logic [4:0]  i_ra = '0;
    logic [63:0] i_disp = '0;
    logic        i_use_cia = 1'b0;
    logic [63:0] i_cia = '0;
    logic        i_32b_mode = 1'b0;
    logic [1:0]  i_size = '0;
    logic [63:0] i_rf_rdata = '0;
    logic        i_dc_req_ready = 1'b0;
    logic        i_dc_rsp_valid = 1'b0;
    logic [63:0] i_dc_rsp_data = '0;
    logic        i_flush = 1'b0;
    logic [4:0]  o_rf_addr;
    logic        o_rf_enr, o_rf_enw, o_dc_req_valid, o_stall, o_done;
    logic        o_err_invalid, o_err_timeout;
    logic [63:0] o_rf_wdata, o_dc_addr;
    logic [1:0]  o_dc_size;

    int n_checks = 0;
    int n_errors = 0;

    // Observations collected by run_load.
    int          obs_done, obs_enr, obs_to, obs_inv;
    int          obs_enw_cnt, obs_req_cnt, obs_stall_cnt, obs_stall_first, obs_stall_last;
    bit          obs_unstable;
    logic [4:0]  obs_wb_addr, obs_enr_addr;
    logic [63:0] obs_wdata, obs_dc_addr;
    logic [1:0]  obs_dc_size;

    lsu_load_sequencer #(.DC_TIMEOUT(TMO)) dut (
        .i_clk(i_clk), .i_rst(i_rst), .i_start(i_start), .i_rt(i_rt), .i_ra(i_ra),
        .i_disp(i_disp), .i_use_cia(i_use_cia), .i_cia(i_cia), .i_32b_mode(i_32b_mode),
        .i_size(i_size), .o_rf_addr(o_rf_addr), .o_rf_enr(o_rf_enr),
        .i_rf_rdata(i_rf_rdata), .o_rf_enw(o_rf_enw), .o_rf_wdata(o_rf_wdata),
        .o_dc_req_valid(o_dc_req_valid), .i_dc_req_ready(i_dc_req_ready),
        .o_dc_addr(o_dc_addr), .o_dc_size(o_dc_size), .i_dc_rsp_valid(i_dc_rsp_valid),
        .i_dc_rsp_data(i_dc_rsp_data), .i_flush(i_flush), .o_stall(o_stall),
        .o_done(o_done), .o_err_invalid(o_err_invalid), .o_err_timeout(o_err_timeout)
    );

    always #5 i_clk = ~i_clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // Reference model: EA from the ISA rules.
    function automatic logic [63:0] model_ea(input logic [4:0] ra, input logic [63:0] rfv,
                                             input logic [63:0] cia, input logic [63:0] disp,
                                             input logic use_cia, input logic m32);
        logic [63:0] base;
        logic [63:0] ea;
        base = (ra != 5'd0) ? rfv : (use_cia ? cia : 64'd0);
        ea = base + disp;
        if (m32) ea = ea % (64'd1 << 32);
        return ea;
    endfunction

    // Reference model: keep the low 8<<size bits.
    function automatic logic [63:0] model_ext(input logic [1:0] size, input logic [63:0] rsp);
        int w;
        w = 8 << size;
        if (w == 64) return rsp;
        return rsp % (64'd1 << w);
    endfunction

    function automatic logic [63:0] rnd64();
        return {$urandom, $urandom};
    endfunction

    task automatic tick();
        @(posedge i_clk);
        #1;
    endtask

    task automatic idle_inputs();
        i_start = 1'b0; i_dc_req_ready = 1'b0; i_dc_rsp_valid = 1'b0; i_flush = 1'b0;
    endtask

    // Drive one load from the current cycle (cycle 0) and record what the DUT does.
    // rd: REQ cycles without ready before the handshake (-1 = never ready).
    // sd: idle WAIT cycles before the response.
    task automatic run_load(input logic [4:0] rt, input logic [4:0] ra, input logic [63:0] disp,
                            input logic [63:0] cia, input logic use_cia, input logic m32,
                            input logic [1:0] size, input logic [63:0] rfv,
                            input logic [63:0] rsp, input int rd, input int sd);
        int hs_cyc;
        bit prev_enr;
        obs_done = -1; obs_enr = -1; obs_to = -1; obs_inv = -1;
        obs_enw_cnt = 0; obs_req_cnt = 0; obs_stall_cnt = 0;
        obs_stall_first = -1; obs_stall_last = -1; obs_unstable = 0;
        obs_wb_addr = '0; obs_enr_addr = '0; obs_wdata = '0; obs_dc_addr = '0; obs_dc_size = '0;
        hs_cyc = -1; prev_enr = 0;
        i_start = 1'b1; i_rt = rt; i_ra = ra; i_disp = disp; i_cia = cia;
        i_use_cia = use_cia; i_32b_mode = m32; i_size = size;
        i_rf_rdata = rnd64();
        for (int c = 1; c <= 80; c++) begin
            tick();
            i_start = 1'b0;
            i_ra = 5'($urandom); i_disp = rnd64(); i_size = 2'($urandom);
            if (o_done && obs_done < 0) begin
                obs_done = c; obs_wdata = o_rf_wdata; obs_wb_addr = o_rf_addr;
            end
            if (o_rf_enw) obs_enw_cnt++;
            if (o_rf_enr) begin obs_enr = c; obs_enr_addr = o_rf_addr; end
            if (o_stall) begin
                obs_stall_cnt++;
                if (obs_stall_first < 0) obs_stall_first = c;
                obs_stall_last = c;
            end
            if (o_dc_req_valid) begin
                if (obs_req_cnt == 0) begin
                    obs_dc_addr = o_dc_addr; obs_dc_size = o_dc_size;
                end else if (o_dc_addr !== obs_dc_addr || o_dc_size !== obs_dc_size) begin
                    obs_unstable = 1;
                end
                obs_req_cnt++;
            end
            if (o_err_timeout && obs_to < 0) obs_to = c;
            if (o_err_invalid && obs_inv < 0) obs_inv = c;
            i_rf_rdata = prev_enr ? rfv : rnd64();
            prev_enr = o_rf_enr;
            i_dc_req_ready = o_dc_req_valid && (rd >= 0) && (obs_req_cnt == rd + 1);
            if (i_dc_req_ready) hs_cyc = c;
            if (hs_cyc >= 0 && c == hs_cyc + 1 + sd) begin
                i_dc_rsp_valid = 1'b1; i_dc_rsp_data = rsp;
            end else begin
                i_dc_rsp_valid = o_dc_req_valid ? 1'($urandom) : 1'b0;
                i_dc_rsp_data = rnd64();
            end
            if (o_done || o_err_timeout || o_err_invalid) break;
        end
        idle_inputs();
    endtask

    task automatic test_reset();
        i_rst = 1'b1;
        idle_inputs();
        tick();
        n_checks++;
        if ({o_rf_addr, o_rf_enr, o_rf_enw, o_rf_wdata, o_dc_req_valid, o_dc_addr, o_dc_size,
             o_stall, o_done, o_err_invalid, o_err_timeout} !== 142'd0) begin
            n_errors++;
            $display("FAIL reset_outputs: got stall=%b enr=%b enw=%b req=%b addr=%h, required all 0",
                     o_stall, o_rf_enr, o_rf_enw, o_dc_req_valid, o_dc_addr);
        end
        tick();
        i_rst = 1'b0;
        tick();
    endtask

    task automatic test_basic();
        run_load(5'd7, 5'd0, 64'h10, 64'h0, 1'b0, 1'b0, 2'b00, 64'h0,
                 64'hFFFF_FFFF_FFFF_FFAB, 0, 0);
        n_checks++;
        if (obs_dc_addr !== 64'h10) begin n_errors++;
            $display("FAIL basic_ea: got %h required %h", obs_dc_addr, 64'h10); end
        n_checks++;
        if (obs_wdata !== 64'hAB) begin n_errors++;
            $display("FAIL basic_wdata: got %h required %h", obs_wdata, 64'hAB); end
        n_checks++;
        if (obs_wb_addr !== 5'd7) begin n_errors++;
            $display("FAIL basic_wb_addr: got %0d required 7", obs_wb_addr); end
        n_checks++;
        if (obs_done != 4) begin n_errors++;
            $display("FAIL basic_latency: got %0d required 4", obs_done); end
        n_checks++;
        if (obs_stall_first != 1 || obs_stall_last != 3 || obs_stall_cnt != 3) begin n_errors++;
            $display("FAIL basic_stall: got first=%0d last=%0d cnt=%0d required 1/3/3",
                     obs_stall_first, obs_stall_last, obs_stall_cnt); end
        n_checks++;
        if (obs_dc_size !== 2'b00 || obs_enw_cnt != 1) begin n_errors++;
            $display("FAIL basic_size_enw: got size=%0d enw=%0d required 0/1",
                     obs_dc_size, obs_enw_cnt); end
        tick();
    endtask

    task automatic test_base_reg();
        run_load(5'd9, 5'd5, 64'h20, 64'h0, 1'b0, 1'b1, 2'b11, 64'hFFFF_FFFF_FFFF_FFF0,
                 64'h1234_5678_9ABC_DEF0, 0, 0);
        n_checks++;
        if (obs_enr != 1 || obs_enr_addr !== 5'd5) begin n_errors++;
            $display("FAIL base_rf_read: got cyc=%0d addr=%0d required 1/5", obs_enr, obs_enr_addr); end
        n_checks++;
        if (obs_dc_addr !== 64'h10) begin n_errors++;
            $display("FAIL base_ea_wrap32: got %h required %h", obs_dc_addr, 64'h10); end
        n_checks++;
        if (obs_done != 5) begin n_errors++;
            $display("FAIL base_latency: got %0d required 5", obs_done); end
        n_checks++;
        if (obs_wdata !== 64'h1234_5678_9ABC_DEF0) begin n_errors++;
            $display("FAIL base_wdata: got %h required %h", obs_wdata, 64'h1234_5678_9ABC_DEF0); end
        tick();
    endtask

    task automatic test_invalid_and_cia();
        run_load(5'd1, 5'd3, 64'h8, 64'h1000, 1'b1, 1'b0, 2'b10, 64'h0, 64'h0, 0, 0);
        n_checks++;
        if (obs_inv != 1) begin n_errors++;
            $display("FAIL invalid_pulse: got cyc=%0d required 1", obs_inv); end
        n_checks++;
        if (obs_stall_cnt != 0 || obs_req_cnt != 0 || obs_enw_cnt != 0) begin n_errors++;
            $display("FAIL invalid_side_effects: got stall=%0d req=%0d enw=%0d required 0",
                     obs_stall_cnt, obs_req_cnt, obs_enw_cnt); end
        tick();
        n_checks++;
        if (o_err_invalid !== 1'b0 || o_stall !== 1'b0) begin n_errors++;
            $display("FAIL invalid_one_cycle: got err=%b stall=%b required 0/0", o_err_invalid, o_stall); end
        run_load(5'd2, 5'd0, 64'hFFFF_FFFF_FFFF_FFFC, 64'h1000, 1'b1, 1'b0, 2'b01, 64'h0,
                 64'hAAAA_BBBB_CCCC_DDDD, 0, 0);
        n_checks++;
        if (obs_dc_addr !== 64'hFFC || obs_wdata !== 64'hDDDD) begin n_errors++;
            $display("FAIL cia_ea: got ea=%h data=%h required %h/%h", obs_dc_addr, obs_wdata,
                     64'hFFC, 64'hDDDD); end
        tick();
    endtask

    task automatic test_ready_delay();
        run_load(5'd4, 5'd0, 64'h40, 64'h0, 1'b0, 1'b0, 2'b10, 64'h0, 64'h5555_6666_7777_8888, 10, 0);
        n_checks++;
        if (obs_done != 14) begin n_errors++;
            $display("FAIL ready_delay_latency: got %0d required 14", obs_done); end
        n_checks++;
        if (obs_unstable || obs_req_cnt != 11 || obs_dc_addr !== 64'h40) begin n_errors++;
            $display("FAIL ready_delay_req: got unstable=%0d req=%0d addr=%h required 0/11/40",
                     obs_unstable, obs_req_cnt, obs_dc_addr); end
        n_checks++;
        if (obs_wdata !== 64'h7777_8888) begin n_errors++;
            $display("FAIL ready_delay_wdata: got %h required %h", obs_wdata, 64'h7777_8888); end
        tick();
    endtask

    task automatic test_timeout();
        run_load(5'd6, 5'd0, 64'h80, 64'h0, 1'b0, 1'b0, 2'b00, 64'h0, 64'h0, -1, 0);
        n_checks++;
        if (obs_to != 2 + int'(TMO)) begin n_errors++;
            $display("FAIL timeout_pulse: got cyc=%0d required %0d", obs_to, 2 + int'(TMO)); end
        n_checks++;
        if (obs_enw_cnt != 0 || obs_done != -1 || obs_req_cnt != int'(TMO)) begin n_errors++;
            $display("FAIL timeout_no_wb: got enw=%0d done=%0d req=%0d required 0/-1/%0d",
                     obs_enw_cnt, obs_done, obs_req_cnt, TMO); end
        n_checks++;
        if (o_stall !== 1'b0 || o_dc_req_valid !== 1'b0) begin n_errors++;
            $display("FAIL timeout_idle: got stall=%b req=%b required 0/0", o_stall, o_dc_req_valid); end
        tick();
    endtask

    task automatic test_back_to_back();
        run_load(5'd10, 5'd0, 64'h100, 64'h0, 1'b0, 1'b0, 2'b00, 64'h0, 64'h11, 0, 0);
        i_start = 1'b1; i_ra = 5'd0; i_disp = 64'h200;
        tick();
        n_checks++;
        if (o_stall !== 1'b0) begin n_errors++;
            $display("FAIL b2b_start_in_wb: got stall=%b required 0", o_stall); end
        run_load(5'd11, 5'd0, 64'h200, 64'h0, 1'b0, 1'b0, 2'b00, 64'h0, 64'h22, 0, 0);
        n_checks++;
        if (obs_done != 4 || obs_dc_addr !== 64'h200 || obs_wdata !== 64'h22) begin n_errors++;
            $display("FAIL b2b_second: got done=%0d ea=%h data=%h required 4/200/22",
                     obs_done, obs_dc_addr, obs_wdata); end
        tick();
    endtask

    task automatic test_flush();
        int enw;
        bit stall_ok;
        enw = 0; stall_ok = 1;
        i_start = 1'b1; i_rt = 5'd12; i_ra = 5'd0; i_disp = 64'h300; i_use_cia = 1'b0;
        i_32b_mode = 1'b0; i_size = 2'b11;
        tick(); i_start = 1'b0;
        tick();
        n_checks++;
        if (o_dc_req_valid !== 1'b1) begin n_errors++;
            $display("FAIL flush_req_reached: got %b required 1", o_dc_req_valid); end
        i_dc_req_ready = 1'b1; i_flush = 1'b1;
        for (int c = 3; c <= 5; c++) begin
            tick();
            i_dc_req_ready = 1'b0; i_flush = 1'b0;
            if (o_stall !== 1'b1) stall_ok = 0;
            if (o_rf_enw) enw++;
            if (c == 5) begin i_dc_rsp_valid = 1'b1; i_dc_rsp_data = 64'hDEAD; end
        end
        tick();
        i_dc_rsp_valid = 1'b0;
        if (o_rf_enw || o_done) enw++;
        n_checks++;
        if (!stall_ok) begin n_errors++;
            $display("FAIL flush_drain_stall: got stall low in DRAIN required high"); end
        n_checks++;
        if (enw != 0 || o_stall !== 1'b0) begin n_errors++;
            $display("FAIL flush_drain_exit: got enw=%0d stall=%b required 0/0", enw, o_stall); end
        tick();
        i_start = 1'b1; i_ra = 5'd5;
        tick(); i_start = 1'b0; i_flush = 1'b1;
        tick(); i_flush = 1'b0;
        n_checks++;
        if (o_stall !== 1'b0 || o_rf_enr !== 1'b0) begin n_errors++;
            $display("FAIL flush_rdra: got stall=%b enr=%b required 0/0", o_stall, o_rf_enr); end
        tick();
        n_checks++;
        if (o_dc_req_valid !== 1'b0) begin n_errors++;
            $display("FAIL flush_rdra_noreq: got %b required 0", o_dc_req_valid); end
    endtask

    task automatic test_reset_mid();
        i_start = 1'b1; i_rt = 5'd13; i_ra = 5'd0; i_disp = 64'h400; i_size = 2'b10;
        tick(); i_start = 1'b0;
        tick(); i_dc_req_ready = 1'b1;
        tick(); i_dc_req_ready = 1'b0;
        n_checks++;
        if (o_stall !== 1'b1) begin n_errors++;
            $display("FAIL rstmid_in_wait: got stall=%b required 1", o_stall); end
        i_rst = 1'b1;
        tick();
        n_checks++;
        if ({o_rf_addr, o_rf_enr, o_rf_enw, o_rf_wdata, o_dc_req_valid, o_dc_addr, o_dc_size,
             o_stall, o_done, o_err_invalid, o_err_timeout} !== 142'd0) begin
            n_errors++;
            $display("FAIL rstmid_outputs: got stall=%b addr=%h size=%0d required all 0",
                     o_stall, o_dc_addr, o_dc_size);
        end
        i_rst = 1'b0;
        tick();
        n_checks++;
        if (o_stall !== 1'b0 || o_rf_enw !== 1'b0) begin n_errors++;
            $display("FAIL rstmid_idle: got stall=%b enw=%b required 0/0", o_stall, o_rf_enw); end
    endtask

    task automatic test_random();
        for (int n = 0; n < 30; n++) begin
            logic [4:0]  rt, ra;
            logic [63:0] disp, cia, rfv, rsp, ea;
            logic        use_cia, m32;
            logic [1:0]  size;
            int rd, sd, lat;
            rt = 5'($urandom); use_cia = 1'($urandom);
            ra = (use_cia || $urandom_range(0, 1) == 0) ? 5'd0 : 5'($urandom_range(1, 31));
            disp = rnd64(); cia = rnd64(); rfv = rnd64(); rsp = rnd64();
            m32 = 1'($urandom); size = 2'($urandom);
            rd = $urandom_range(0, 3); sd = $urandom_range(0, 3);
            ea = model_ea(ra, rfv, cia, disp, use_cia, m32);
            lat = 4 + ((ra != 5'd0) ? 1 : 0) + rd + sd;
            run_load(rt, ra, disp, cia, use_cia, m32, size, rfv, rsp, rd, sd);
            n_checks++;
            if (obs_dc_addr !== ea || obs_dc_size !== size || obs_unstable) begin n_errors++;
                $display("FAIL rand_req[%0d]: got ea=%h size=%0d unstable=%0d required %h/%0d/0",
                         n, obs_dc_addr, obs_dc_size, obs_unstable, ea, size); end
            n_checks++;
            if (obs_wdata !== model_ext(size, rsp) || obs_wb_addr !== rt) begin n_errors++;
                $display("FAIL rand_wb[%0d]: got data=%h rt=%0d required %h/%0d",
                         n, obs_wdata, obs_wb_addr, model_ext(size, rsp), rt); end
            n_checks++;
            if (obs_done != lat || obs_stall_cnt != lat - 1 || obs_enw_cnt != 1) begin n_errors++;
                $display("FAIL rand_timing[%0d]: got done=%0d stall=%0d enw=%0d required %0d/%0d/1",
                         n, obs_done, obs_stall_cnt, obs_enw_cnt, lat, lat - 1); end
            tick();
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_base_reg();
        test_invalid_and_cia();
        test_ready_delay();
        test_timeout();
        test_back_to_back();
        test_flush();
        test_reset_mid();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/lsu_load_sequencer.md
# lsu_load_sequencer

Multi-cycle sequencer for the fixed-point byte/halfword/word/doubleword zero-loads (lbz and plbz family) in the FixedPoint core. It sits between decode and the register file / data-cache ports. For each accepted load it reads the base register, forms the effective address (EA), issues a handshaked data-cache request and waits for the response. It then writes the zero-extended result to RT, holding the pipeline stalled for the duration. All vectors use Power ISA big-endian bit numbering: bit 0 is the MSB.

## Interface

Parameters:
- DC_TIMEOUT, 255: maximum cycles spent in REQ plus WAIT before the load is abandoned.

Ports:
- i_clk  in  1  clock; all state updates on the rising edge.
- i_rst  in  1  synchronous, active-high reset.
- i_start  in  1  decoded load valid; accepted only in IDLE, ignored otherwise.
- i_rt  in  5  target register.
- i_ra  in  5  base register; 0 means no base.
- i_disp  in  64  displacement, already sign-extended (EXTS64(D) or EXTS64(d0||d1)).
- i_use_cia  in  1  prefixed R=1 form; base is i_cia.
- i_cia  in  64  current instruction address.
- i_32b_mode  in  1  EA bits 0:31 forced to zero.
- i_size  in  2  00 byte, 01 half, 10 word, 11 dword.
- o_rf_addr  out  5  register-file index: RA in RDRA, RT in WB, else 0.
- o_rf_enr  out  1  register-file read enable; read data valid the next cycle.
- i_rf_rdata  in  64  register-file read data.
- o_rf_enw  out  1  register-file write enable.
- o_rf_wdata  out  64  write data.
- o_dc_req_valid  out  1  data-cache request valid.
- i_dc_req_ready  in  1  data-cache request ready.
- o_dc_addr  out  64  EA.
- o_dc_size  out  2  latched i_size.
- i_dc_rsp_valid  in  1  response valid.
- i_dc_rsp_data  in  64  response; the addressed value is right-justified.
- i_flush  in  1  abort the current load.
- o_stall  out  1  pipeline stall request.
- o_done  out  1  one-cycle pulse when writeback occurs.
- o_err_invalid  out  1  one-cycle pulse: invalid form (i_use_cia=1 with i_ra≠0).
- o_err_timeout  out  1  one-cycle pulse: load abandoned after DC_TIMEOUT.

## Operation

States: IDLE, RDRA, ADDR, REQ, WAIT, WB, DRAIN.

- **IDLE, i_start=1:** latch rt, ra, disp, use_cia, cia, 32b_mode and size.
  - If use_cia and ra≠0: pulse o_err_invalid next cycle and remain in IDLE.
  - Else if ra≠0: go to RDRA.
  - Else: go to ADDR, with base = cia if use_cia, else 0.
- **RDRA:** o_rf_enr=1 and o_rf_addr=ra. Go to ADDR.
- **ADDR:**
  - base = i_rf_rdata if RA was read.
  - EA = base + disp, modulo 2^64. If 32b_mode, EA[0:31]=0.
  - Register EA and clear the timeout counter. Go to REQ.
- **REQ:** o_dc_req_valid=1; o_dc_addr and o_dc_size are held stable. When i_dc_req_ready=1, go to WAIT. i_dc_rsp_valid is ignored in REQ.
- **WAIT:** when i_dc_rsp_valid=1, capture the data zero-extended per size, keeping bits 56:63, 48:63, 32:63 or 0:63. Go to WB.
- **WB:** o_rf_enw=1, o_rf_addr=rt, o_rf_wdata holds the captured value, o_done=1. Go to IDLE.
- **Timeout:** the counter increments in every REQ and WAIT cycle. When it reaches DC_TIMEOUT, pulse o_err_timeout, go to IDLE and do not write back. Timeout in WAIT goes to DRAIN instead of IDLE.
- **Flush (i_flush=1):**
  - In RDRA, ADDR, or REQ without a handshake: go to IDLE.
  - In REQ with a handshake in the same cycle, or in WAIT without a response: go to DRAIN.
  - In WAIT with a response in the same cycle: go to IDLE with no writeback.
  - In WB: the writeback completes.
  - In IDLE or DRAIN: no effect.
- **DRAIN:** wait for i_dc_rsp_valid, discard the data and go to IDLE. No register-file write occurs.
- **o_stall:** 1 in RDRA, ADDR, REQ, WAIT and DRAIN; 0 in IDLE and WB.

## Timing

- **Reset:** state=IDLE, counter=0, EA=0. Every output is 0 the cycle after i_rst is sampled high. Reset mid-load aborts the load with no writeback and does not wait for an outstanding response.
- **Latency:** cycle N is i_start, ready is immediate, and the response arrives the cycle after the handshake.
  - ra=0: WB (o_done) at N+4.
  - ra≠0: WB (o_done) at N+5.
- **Stall timing:** o_stall rises at N+1 and falls in WB. Upstream must not present a new i_start while o_stall=1.
- **Back-to-back:** i_start in the WB cycle is ignored; i_start is accepted in the next IDLE cycle.
- **EA wrap-around:** a carry out of bit 0 is discarded.

## Test plan

- **ra=0, disp=0x0000_0000_0000_0010, size=00, ready=1, rsp=0xFFFF_FFFF_FFFF_FFAB:** o_dc_addr=0x10, o_rf_wdata=0xAB, o_rf_addr=rt, o_done at N+4, o_stall high N+1..N+3.
- **ra=5 with i_rf_rdata=0xFFFF_FFFF_FFFF_FFF0, disp=0x20, 32b_mode=1:** o_rf_enr with addr 5 at N+1, EA=0x0000_0000_0000_0010 (wrapped, upper half cleared), o_done at N+5.
- **use_cia=1, ra=3:** o_err_invalid pulse at N+1, no o_stall, no dc request. Then **use_cia=1, ra=0, cia=0x1000, disp=-4:** EA=0xFFC.
- **ready held 0 for 10 cycles, then the response:** o_dc_req_valid and o_dc_addr stable throughout, completion 10 cycles later than the baseline.
- **DC_TIMEOUT=8, no ready:** o_err_timeout after 8 REQ cycles, no o_rf_enw, return to IDLE.
- **Flush in the handshake cycle:** enters DRAIN and o_stall stays high. The response arriving 3 cycles later is discarded with no o_rf_enw, then IDLE. Reset asserted in WAIT returns all outputs to 0 next cycle.
